// File: rtl/rv32e_alu_arbiter_if.sv
// Purpose: bundle of both requester channels and the ALU drive/return for rv32e_alu_arbiter.
// Latency: none (wiring only).
// Backpressure: reqN_ready and rspN_ready carry the valid/ready flow control for each requester.
//
// Ports (signals):
//   reqN_valid/ready/op/a/b/tag   request channel N (N = 0, 1)
//   rspN_valid/ready/result/flags/tag   response channel N, flags = {overflow, negative, zero}
//   alu_op/a/b                    operands towards the external combinational ALU
//   alu_result/zero/negative/overflow   results back from the ALU
// Modports: slave = arbiter side, master = requesters + ALU side.
interface rv32e_alu_arbiter_if #(
    parameter int TAG_W = 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [31:0]      rsp0_result;
    logic [2:0]       rsp0_flags;
    logic [TAG_W-1:0] rsp0_tag;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [31:0]      rsp1_result;
    logic [2:0]       rsp1_flags;
    logic [TAG_W-1:0] rsp1_tag;

    logic [3:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_negative;
    logic             alu_overflow;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flags, rsp0_tag,
        input  rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_flags, rsp1_tag,
        input  rsp1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result, alu_zero, alu_negative, alu_overflow
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flags, rsp0_tag,
        output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_flags, rsp1_tag,
        output rsp1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result, alu_zero, alu_negative, alu_overflow
    );
endinterface

// File: rtl/rv32e_alu_arbiter.sv
// Purpose: shares one combinational RV32E ALU between execute (req 0) and AGU/aux (req 1), round-robin.
// Latency: 1 cycle, request accepted at edge k -> response slot valid after edge k.
// Backpressure: a full response slot that is not being popped blocks its own requester only.
//
// Ports:
//   clk   clock, all state on rising edge
//   rst   synchronous active-high reset
//   bus   rv32e_alu_arbiter_if.slave: two req/rsp valid-ready channel pairs plus ALU drive/return
// Option macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties, no last_grant state
// (requester 1 can starve). Undefined: round-robin on ties.
module rv32e_alu_arbiter #(
    parameter int TAG_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    rv32e_alu_arbiter_if.slave       bus
);

    typedef struct packed {
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [31:0]      result;
        logic [2:0]       flags;    // {overflow, negative, zero}
        logic [TAG_W-1:0] tag;
    } slot_t;

    req_t        req [2];
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  elig;
    logic [1:0]  grant;
    req_t        win;
    logic [2:0]  alu_flags;

    logic [1:0]  slot_vld;
    slot_t       slot [2];

    // ------------------------------------------------------------------
    // Request side gathering
    // ------------------------------------------------------------------
    assign req[0]       = '{bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_tag};
    assign req[1]       = '{bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_tag};
    assign req_valid    = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready    = {bus.rsp1_ready, bus.rsp0_ready};

    // A requester may only win if its slot is free now or is being popped
    // this cycle. Reset gates eligibility so nothing is accepted while rst=1.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = !rst && req_valid[i] && (!slot_vld[i] || rsp_ready[i]);
        end
    end

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant[0] = elig[0];
    assign grant[1] = elig[1] && !elig[0];
`else
    // last_grant names the most recent winner; on a tie the other one wins.
    // Resets to 1 so requester 0 takes the first tie.
    logic last_grant;

    assign grant[0] = elig[0] && (!elig[1] || last_grant);
    assign grant[1] = elig[1] && (!elig[0] || !last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            last_grant <= 1'b1;
        end
    end
`endif

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    // ------------------------------------------------------------------
    // ALU drive: winner's operands, otherwise an idle ADD 0+0
    // ------------------------------------------------------------------
    always_comb begin
        win = '0;
        if (grant[0]) begin
            win = req[0];
        end else if (grant[1]) begin
            win = req[1];
        end
    end

    assign bus.alu_op = win.op;
    assign bus.alu_a  = win.a;
    assign bus.alu_b  = win.b;

    assign alu_flags  = {bus.alu_overflow, bus.alu_negative, bus.alu_zero};

    // ------------------------------------------------------------------
    // Response slots. An accept takes precedence over a pop on the same
    // slot, so a simultaneous pop+accept keeps the slot valid with new data.
    // Data is left stale on a plain pop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
            for (int i = 0; i < 2; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    slot_vld[i] <= 1'b1;
                    slot[i]     <= slot_t'{bus.alu_result, alu_flags, win.tag};
                end else if (rsp_ready[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp0_valid  = slot_vld[0];
    assign bus.rsp0_result = slot[0].result;
    assign bus.rsp0_flags  = slot[0].flags;
    assign bus.rsp0_tag    = slot[0].tag;

    assign bus.rsp1_valid  = slot_vld[1];
    assign bus.rsp1_result = slot[1].result;
    assign bus.rsp1_flags  = slot[1].flags;
    assign bus.rsp1_tag    = slot[1].tag;

    // At most one winner per cycle.
    a_onehot_grant: assert property (@(posedge clk) $onehot0(grant));

endmodule
